i_cache_2way: RTL and testbench

Two-way set-associative, read-only instruction cache. It is the parametrised successor to the direct-mapped instruction cache and sits between the fetch stage and the instruction memory burst interface. Over the direct-mapped version it adds a configurable line size, LRU replacement, a flush command, refill-abort safety and saturating hit/miss counters.

---
 rtl/i_cache_2way.sv | 200 ++++++++++++++++++++
 tb/tb_i_cache_2way.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i_cache_2way.sv
// i_cache_2way
// Two-way set-associative, read-only instruction cache between the fetch
// stage and a burst-refill instruction memory. Hits return data in the same
// cycle as the request. A miss refills one whole line into a victim way, and
// the requested word is forwarded as it streams past.
//
// Ports:
//   i_Clk, i_Reset_n             clock, asynchronous active-low reset
//   i_Valid, i_Address           fetch request (word address {tag,index,offset})
//   i_Flush                      invalidate every line
//   o_MEM_Valid, o_MEM_Address   refill request (line-aligned address)
//   i_MEM_Valid, i_MEM_Last,
//   i_MEM_Data                   refill beats, in offset order 0..WORDS-1
//   o_Ready                      cache can accept a request this cycle
//   o_Valid, o_Data              requested word (o_Data is 0 when not valid)
//   o_Hit_Count, o_Miss_Count    saturating statistics
module i_cache_2way #(
  parameter int DATA_WIDTH         = 32,
  parameter int TAG_WIDTH          = 14,
  parameter int INDEX_WIDTH        = 5,
  parameter int BLOCK_OFFSET_WIDTH = 2,
  parameter int CNT_WIDTH          = 16,
  localparam int AW = TAG_WIDTH + INDEX_WIDTH + BLOCK_OFFSET_WIDTH
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset_n,
  input  logic                  i_Valid,
  input  logic [AW-1:0]         i_Address,
  input  logic                  i_Flush,
  output logic                  o_MEM_Valid,
  output logic [AW-1:0]         o_MEM_Address,
  input  logic                  i_MEM_Valid,
  input  logic                  i_MEM_Last,
  input  logic [DATA_WIDTH-1:0] i_MEM_Data,
  output logic                  o_Ready,
  output logic                  o_Valid,
  output logic [DATA_WIDTH-1:0] o_Data,
  output logic [CNT_WIDTH-1:0]  o_Hit_Count,
  output logic [CNT_WIDTH-1:0]  o_Miss_Count
);

  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << BLOCK_OFFSET_WIDTH;
  localparam logic [BLOCK_OFFSET_WIDTH-1:0] LAST_WORD = BLOCK_OFFSET_WIDTH'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_READY,
    ST_MISS,
    ST_FLUSH
  } state_e;

  state_e state_q, state_d;

  // Line storage: valid and LRU bits need a known reset value, the arrays do not.
  logic [1:0][SETS-1:0]  valid_q;
  logic [SETS-1:0]       lru_q;      // lru_q[set] names the next victim way
  logic [TAG_WIDTH-1:0]  tag_q  [2][SETS];
  logic [DATA_WIDTH-1:0] data_q [2][SETS][WORDS];

  // Refill context captured on the missing request.
  logic [TAG_WIDTH-1:0]          r_tag_q;
  logic [INDEX_WIDTH-1:0]        r_index_q;
  logic [BLOCK_OFFSET_WIDTH-1:0] r_offset_q;
  logic                          victim_q;
  logic [BLOCK_OFFSET_WIDTH-1:0] k_q;
  logic                          flush_pend_q;

  logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q;

  // Request decode.
  logic [TAG_WIDTH-1:0]          req_tag;
  logic [INDEX_WIDTH-1:0]        req_index;
  logic [BLOCK_OFFSET_WIDTH-1:0] req_offset;
  assign {req_tag, req_index, req_offset} = i_Address;

  logic hit0, hit1, hit_way, victim_sel;
  assign hit0 = valid_q[0][req_index] && (tag_q[0][req_index] == req_tag);
  assign hit1 = valid_q[1][req_index] && (tag_q[1][req_index] == req_tag);
  // A tag can only live in one way, but if both match way 0 wins.
  assign hit_way = hit0 ? 1'b0 : 1'b1;
  // Fill an empty way first (way 0 preferred) before evicting anything.
  assign victim_sel = !valid_q[0][req_index] ? 1'b0 :
                      !valid_q[1][req_index] ? 1'b1 : lru_q[req_index];

  assign o_MEM_Address = {r_tag_q, r_index_q, {BLOCK_OFFSET_WIDTH{1'b0}}};
  assign o_Hit_Count   = hit_cnt_q;
  assign o_Miss_Count  = miss_cnt_q;

  // Per-cycle events decoded by the FSM and consumed by the registers below.
  logic hit_req, miss_req, refill_beat, refill_done;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d     = state_q;
    o_Ready     = 1'b0;
    o_Valid     = 1'b0;
    o_Data      = '0;
    o_MEM_Valid = 1'b0;
    hit_req     = 1'b0;
    miss_req    = 1'b0;
    refill_beat = 1'b0;
    refill_done = 1'b0;
    case (state_q)
      ST_READY: begin
        o_Ready = 1'b1;
        if (i_Flush) begin
          // Flush wins; a simultaneous fetch is dropped uncounted.
          state_d = ST_FLUSH;
        end else if (i_Valid) begin
          if (hit0 || hit1) begin
            hit_req = 1'b1;
            o_Valid = 1'b1;
            o_Data  = data_q[hit_way][req_index][req_offset];
          end else begin
            miss_req = 1'b1;
            state_d  = ST_MISS;
          end
        end
      end
      ST_MISS: begin
        o_MEM_Valid = 1'b1;
        if (i_MEM_Valid) begin
          refill_beat = 1'b1;
          if (k_q == r_offset_q) begin
            o_Valid = 1'b1;
            o_Data  = i_MEM_Data;
          end
          if (i_MEM_Last) begin
            refill_done = 1'b1;
            state_d     = (flush_pend_q || i_Flush) ? ST_FLUSH : ST_READY;
          end
        end
      end
      ST_FLUSH: state_d = ST_READY;
      default:  state_d = ST_READY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q      <= ST_READY;
      valid_q      <= '0;
      lru_q        <= '0;
      r_tag_q      <= '0;
      r_index_q    <= '0;
      r_offset_q   <= '0;
      victim_q     <= 1'b0;
      k_q          <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q <= state_d;

      if (hit_req) begin
        lru_q[req_index] <= ~hit_way;
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      end

      if (miss_req) begin
        r_tag_q      <= req_tag;
        r_index_q    <= req_index;
        r_offset_q   <= req_offset;
        victim_q     <= victim_sel;
        k_q          <= '0;
        flush_pend_q <= 1'b0;
        // The victim's old contents are overwritten beat by beat, so it must
        // stop hitting now; it only becomes valid again after a full burst.
        valid_q[victim_sel][req_index] <= 1'b0;
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end

      if (state_q == ST_MISS && i_Flush) flush_pend_q <= 1'b1;

      if (refill_beat) k_q <= k_q + 1'b1;

      if (refill_done) begin
        if (k_q == LAST_WORD) valid_q[victim_q][r_index_q] <= 1'b1;
        lru_q[r_index_q] <= ~victim_q;
      end

      if (state_q == ST_FLUSH) begin
        valid_q      <= '0;
        lru_q        <= '0;
        flush_pend_q <= 1'b0;
      end
    end
  end

  // NOTE: tag and data arrays are not reset; the valid bits guard every read,
  // and leaving them out of reset lets them map onto plain RAM.
  always_ff @(posedge i_Clk) begin
    if (refill_beat) data_q[victim_q][r_index_q][k_q] <= i_MEM_Data;
    if (refill_done && k_q == LAST_WORD) tag_q[victim_q][r_index_q] <= r_tag_q;
  end

endmodule

// File: tb/tb_i_cache_2way.sv
// Directed bench for i_cache_2way. Stimulus pushes the word it expects the
// cache to return; a negedge monitor pops and compares whenever o_Valid is
// high. Control outputs and counters are checked inline.
module tb_i_cache_2way;

  localparam int AW  = 21;
  localparam int OFF = 2;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_Valid, i_Flush, i_MEM_Valid, i_MEM_Last;
  logic [AW-1:0] i_Address;
  logic [31:0]   i_MEM_Data;
  logic          o_MEM_Valid, o_Ready, o_Valid;
  logic [AW-1:0] o_MEM_Address;
  logic [31:0]   o_Data;
  logic [CW-1:0] o_Hit_Count, o_Miss_Count;

  i_cache_2way #(.CNT_WIDTH(CW)) dut (
    .i_Clk        (clk),
    .i_Reset_n    (rst_n),
    .i_Valid      (i_Valid),
    .i_Address    (i_Address),
    .i_Flush      (i_Flush),
    .o_MEM_Valid  (o_MEM_Valid),
    .o_MEM_Address(o_MEM_Address),
    .i_MEM_Valid  (i_MEM_Valid),
    .i_MEM_Last   (i_MEM_Last),
    .i_MEM_Data   (i_MEM_Data),
    .o_Ready      (o_Ready),
    .o_Valid      (o_Valid),
    .o_Data       (o_Data),
    .o_Hit_Count  (o_Hit_Count),
    .o_Miss_Count (o_Miss_Count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (o_Valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(o_Valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("read_data", o_Data, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    i_Valid     = 1'b0;
    i_Flush     = 1'b0;
    i_MEM_Valid = 1'b0;
    i_MEM_Last  = 1'b0;
    i_MEM_Data  = '0;
    i_Address   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One-cycle fetch; on an expected hit the word is queued for the monitor.
  task automatic fetch(input logic [AW-1:0] a, input bit hit, input logic [31:0] d);
    i_Valid   = 1'b1;
    i_Address = a;
    if (hit) exp_q.push_back(d);
    tick();
    i_Valid = 1'b0;
  endtask

  // Feeds n beats (base+i) with Last on the final one; optional flush on beat fb.
  task automatic refill(input logic [AW-1:0] a, input int n, input logic [31:0] base,
                        input int fb);
    logic [AW-1:0]  line;
    logic [OFF-1:0] off;
    line = {a[AW-1:OFF], {OFF{1'b0}}};
    off  = a[OFF-1:0];
    for (int i = 0; i < n; i++) begin
      check("mem_valid_high", 32'(o_MEM_Valid), 32'd1);
      check("mem_address", 32'(o_MEM_Address), 32'(line));
      check("ready_low_in_miss", 32'(o_Ready), 32'd0);
      i_MEM_Valid = 1'b1;
      i_MEM_Data  = base + 32'(i);
      i_MEM_Last  = (i == n - 1);
      i_Flush     = (i == fb);
      if (i == int'(off)) exp_q.push_back(base + 32'(i));
      tick();
    end
    i_MEM_Valid = 1'b0;
    i_MEM_Last  = 1'b0;
    i_Flush     = 1'b0;
    check("mem_valid_fall", 32'(o_MEM_Valid), 32'd0);
  endtask

  initial begin
    do_reset();
    check("reset_ready", 32'(o_Ready), 32'd1);
    check("reset_mem_valid", 32'(o_MEM_Valid), 32'd0);
    check("reset_valid", 32'(o_Valid), 32'd0);
    check("reset_hits", 32'(o_Hit_Count), 32'd0);
    check("reset_misses", 32'(o_Miss_Count), 32'd0);

    // Cold miss then hit: index 4 offset 2, refill line 0x10.
    fetch(21'h00012, 1'b0, '0);
    refill(21'h00012, 4, 32'hD000_0000, -1);
    check("ready_after_refill", 32'(o_Ready), 32'd1);
    fetch(21'h00013, 1'b1, 32'hD000_0003);
    check("t1_hits", 32'(o_Hit_Count), 32'd1);
    check("t1_misses", 32'(o_Miss_Count), 32'd1);

    // Two-way conflict in set 5: tags A=1, B=2, C=3.
    do_reset();
    fetch(21'h00094, 1'b0, '0);
    refill(21'h00094, 4, 32'hA000_0000, -1);
    fetch(21'h00114, 1'b0, '0);
    refill(21'h00114, 4, 32'hB000_0000, -1);
    fetch(21'h00095, 1'b1, 32'hA000_0001);   // A now most recent, B victim
    fetch(21'h00196, 1'b0, '0);
    refill(21'h00196, 4, 32'hC000_0000, -1); // evicts B
    fetch(21'h00097, 1'b1, 32'hA000_0003);
    fetch(21'h00115, 1'b0, '0);              // B must miss
    refill(21'h00115, 4, 32'hB100_0000, -1);
    check("t2_hits", 32'(o_Hit_Count), 32'd2);
    check("t2_misses_saturated", 32'(o_Miss_Count), 32'd3);

    // Flush from READY with a simultaneous fetch.
    do_reset();
    fetch(21'h00040, 1'b0, '0);
    refill(21'h00040, 4, 32'hE000_0000, -1);
    fetch(21'h00041, 1'b1, 32'hE000_0001);
    i_Flush = 1'b1;
    fetch(21'h00041, 1'b0, '0);              // dropped: no expected word
    i_Flush = 1'b0;
    check("flush_ready_low", 32'(o_Ready), 32'd0);
    check("flush_mem_valid", 32'(o_MEM_Valid), 32'd0);
    tick();
    check("flush_ready_back", 32'(o_Ready), 32'd1);
    check("flush_req_not_counted", 32'(o_Hit_Count), 32'd1);
    fetch(21'h00041, 1'b0, '0);
    refill(21'h00041, 4, 32'hF000_0000, -1);
    check("flush_refetch_missed", 32'(o_Miss_Count), 32'd2);

    // Flush during refill: forwarded word still delivered, then one FLUSH cycle.
    do_reset();
    fetch(21'h00012, 1'b0, '0);
    refill(21'h00012, 4, 32'h4400_0000, 1);
    check("pend_flush_ready_low", 32'(o_Ready), 32'd0);
    tick();
    check("pend_flush_ready_back", 32'(o_Ready), 32'd1);
    fetch(21'h00012, 1'b0, '0);
    refill(21'h00012, 4, 32'h4500_0000, -1);
    fetch(21'h00013, 1'b1, 32'h4500_0003);

    // Reset mid-refill: asynchronous, no clock edge needed.
    do_reset();
    fetch(21'h00012, 1'b0, '0);
    for (int i = 0; i < 2; i++) begin
      i_MEM_Valid = 1'b1;
      i_MEM_Data  = 32'h5000_0000 + 32'(i);
      tick();
    end
    i_MEM_Valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mem_valid", 32'(o_MEM_Valid), 32'd0);
    check("async_rst_ready", 32'(o_Ready), 32'd1);
    check("async_rst_hits", 32'(o_Hit_Count), 32'd0);
    check("async_rst_misses", 32'(o_Miss_Count), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    fetch(21'h00012, 1'b0, '0);
    refill(21'h00012, 4, 32'h5500_0000, -1);
    check("rst_refetch_missed", 32'(o_Miss_Count), 32'd1);

    // Short burst leaves the line invalid; stray beats in READY are ignored.
    do_reset();
    fetch(21'h00024, 1'b0, '0);
    refill(21'h00024, 2, 32'h6600_0000, -1);
    fetch(21'h00024, 1'b0, '0);
    refill(21'h00024, 4, 32'h7700_0000, -1);
    i_MEM_Valid = 1'b1;
    i_MEM_Last  = 1'b1;
    i_MEM_Data  = 32'hBAD0_BAD0;
    tick();
    i_MEM_Valid = 1'b0;
    i_MEM_Last  = 1'b0;
    check("stray_beat_ready", 32'(o_Ready), 32'd1);
    for (int i = 0; i < 5; i++)
      fetch(21'h00024 + 21'(i % 4), 1'b1, 32'h7700_0000 + 32'(i % 4));
    check("hit_saturation", 32'(o_Hit_Count), 32'd3);
    check("short_burst_misses", 32'(o_Miss_Count), 32'd2);

    tick();
    check("pending_expected_words", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
